// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter that shares one async-FIFO write port among NUM_REQ producers.
// A burst ends on the last word, on the MAX_BURST cap, or when the owner drops req.
module fifo_write_arbiter #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                     wclk,
   input  logic                     wrst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*DSIZE-1:0] req_data,
   input  logic [NUM_REQ-1:0]       req_last,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       accept,
   output logic                     winc,
   output logic [DSIZE-1:0]         wData,
   input  logic                     wFull,
   output logic                     busy
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CntW = $clog2(MAX_BURST + 1);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
   localparam logic [CntW-1:0] CapCnt  = CntW'(MAX_BURST - 1);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e            state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;

   logic [IdxW-1:0]   pick_idx;
   logic              pick_valid;
   logic [IdxW-1:0]   gnt_idx;
   logic              gnt_req;
   logic              gnt_last;
   logic              burst_end;
   logic [DSIZE-1:0]  wdata_mux;

   function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      return IdxW'(sum % NUM_REQ);
   endfunction

   // First requester at or after rr_ptr, wrapping around.
   always_comb begin : pick_comb
      logic [IdxW-1:0] cand;
      cand       = '0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = wrap_add(rr_ptr_q, k);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) gnt_idx = IdxW'(i);
      end
   end

   // grant_q is zero outside a burst, so the mux yields zero data when idle.
   always_comb begin
      wdata_mux = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         wdata_mux |= req_data[i*DSIZE +: DSIZE] & {DSIZE{grant_q[i]}};
      end
   end

   assign gnt_req  = |(grant_q & req);
   assign gnt_last = |(grant_q & req_last);
   assign busy     = (state_q == StBurst);
   assign winc     = busy & gnt_req & ~wFull;
   assign accept   = grant_q & {NUM_REQ{winc}};
   assign grant    = grant_q;
   assign wData    = wdata_mux;

   // A dropped req ends the burst even while the FIFO is full.
   assign burst_end = (winc & (gnt_last | (burst_cnt_q == CapCnt))) | ~gnt_req;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d     = StBurst;
               grant_d     = NUM_REQ'(1) << pick_idx;
               burst_cnt_d = '0;
            end
         end
         StBurst: begin
            if (winc) burst_cnt_d = burst_cnt_q + 1'b1;
            if (burst_end) begin
               state_d     = StIdle;
               grant_d     = '0;
               burst_cnt_d = '0;
               rr_ptr_d    = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (!wrst) begin
         state_q     <= StIdle;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   a_grant_onehot0: assert property (@(posedge wclk) disable iff (!wrst) $onehot0(grant_q));
   a_winc_not_full: assert property (@(posedge wclk) disable iff (!wrst) winc |-> !wFull);
   a_accept_in_grant: assert property (@(posedge wclk) disable iff (!wrst)
                                       (accept & ~grant_q) == '0);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: queue-driven producers, a per-cycle reference model,
// and directed scenarios with hand-computed write logs.
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int D  = 8;
   localparam int MB = 4;

   logic           wclk;
   logic           wrst;
   logic [N-1:0]   req;
   logic [N*D-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   grant;
   logic [N-1:0]   accept;
   logic           winc;
   logic [D-1:0]   wData;
   logic           wFull;
   logic           busy;

   fifo_write_arbiter #(
      .NUM_REQ  (N),
      .DSIZE    (D),
      .MAX_BURST(MB)
   ) dut (
      .wclk    (wclk),
      .wrst    (wrst),
      .req     (req),
      .req_data(req_data),
      .req_last(req_last),
      .grant   (grant),
      .accept  (accept),
      .winc    (winc),
      .wData   (wData),
      .wFull   (wFull),
      .busy    (busy)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;
   int cyc      = 0;

   // Producer queues: each requester presents its head word until accepted.
   logic [7:0] pdata [N][16];
   bit         plast [N][16];
   int         phead [N];
   int         pcnt  [N];
   logic [N-1:0] acc_q = '0;

   // Write log observed at the DUT's FIFO port.
   int w_who  [$];
   int w_data [$];
   int w_cyc  [$];

   // Reference model state.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_words = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (phead[i] < pcnt[i]) begin
            req[i]             = 1'b1;
            req_data[i*D +: D] = pdata[i][phead[i]];
            req_last[i]        = plast[i][phead[i]];
         end else begin
            req[i]             = 1'b0;
            req_data[i*D +: D] = '0;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic load(input int i, input logic [7:0] data, input bit last);
      pdata[i][pcnt[i]] = data;
      plast[i][pcnt[i]] = last;
      pcnt[i]++;
      drive_inputs();
   endtask

   task automatic clear_producers();
      for (int i = 0; i < N; i++) begin
         phead[i] = 0;
         pcnt[i]  = 0;
      end
      drive_inputs();
   endtask

   task automatic clear_logs();
      w_who.delete();
      w_data.delete();
      w_cyc.delete();
   endtask

   task automatic tick();
      @(posedge wclk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_q[i]) phead[i]++;
      end
      drive_inputs();
   endtask

   task automatic do_reset();
      clear_producers();
      wFull = 1'b0;
      wrst  = 1'b0;
      tick();
      tick();
      wrst = 1'b1;
      clear_logs();
   endtask

   task automatic wait_writes(input string name, input int n, input int budget);
      int b;
      b = 0;
      while (w_who.size() < n && b < budget) begin
         tick();
         b++;
      end
      check({name, "_count"}, w_who.size(), n);
   endtask

   task automatic exp_log(input string name, input int k, input int who, input int data);
      check($sformatf("%s_who%0d", name, k), (k < w_who.size()) ? w_who[k] : 32'hdead, who);
      check($sformatf("%s_data%0d", name, k), (k < w_data.size()) ? w_data[k] : 32'hdead, data);
   endtask

   task automatic exp_gap(input string name, input int k, input int gap);
      int d;
      d = (k < w_cyc.size() && k > 0) ? w_cyc[k] - w_cyc[k-1] : -1;
      check($sformatf("%s_gap%0d", name, k), d, gap);
   endtask

   // Model update at the active edge, from the rules: reset, round-robin pick, burst end.
   initial forever begin : model
      int  c;
      bit  w;
      @(posedge wclk);
      cyc++;
      if (!wrst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_words = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (m_owner < 0 && req[c]) m_owner = c;
         end
         m_words = 0;
      end else begin
         w = req[m_owner] && !wFull;
         if (w) m_words++;
         if (!req[m_owner] || (w && (req_last[m_owner] || m_words == MB))) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_words = 0;
         end
      end
   end

   // Mid-cycle: log writes, remember accepts, compare outputs with the model.
   initial forever begin : compare
      logic [N-1:0] eg;
      logic [N-1:0] ea;
      logic [D-1:0] ed;
      logic         ew;
      logic         eb;
      int           who;
      @(negedge wclk);
      acc_q = accept;
      if (winc === 1'b1) begin
         who = 99;
         for (int i = 0; i < N; i++) if (grant[i]) who = i;
         w_who.push_back(who);
         w_data.push_back(int'(wData));
         w_cyc.push_back(cyc);
      end
      if (chk_en) begin
         eb = (m_owner >= 0);
         eg = eb ? (N'(1) << m_owner) : '0;
         ew = eb ? (req[m_owner] && !wFull) : 1'b0;
         ed = eb ? req_data[m_owner*D +: D] : '0;
         ea = ew ? eg : '0;
         check("grant", grant, eg);
         check("winc", winc, ew);
         check("wData", wData, ed);
         check("accept", accept, ea);
         check("busy", busy, eb);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      wrst     = 1'b0;
      wFull    = 1'b0;
      req      = '0;
      req_data = '0;
      req_last = '0;
      clear_producers();
      tick();
      chk_en = 1;

      // Reset held with every requester asserting; then req0 wins first.
      for (int i = 0; i < N; i++) load(i, 8'h10 + 8'(i), 1'b1);
      tick();
      #2;
      check("rst_grant", grant, 0);
      check("rst_winc", winc, 0);
      check("rst_busy", busy, 0);
      tick();
      wrst = 1'b1;
      tick();
      #2;
      check("rst_first_grant", grant, 4'b0001);
      wait_writes("rst", 4, 40);
      for (int k = 0; k < N; k++) exp_log("rst", k, k, 8'h10 + k);

      // Single three-word burst from req1.
      do_reset();
      load(1, 8'hA1, 1'b0);
      load(1, 8'hA2, 1'b0);
      load(1, 8'hA3, 1'b1);
      #2;
      check("single_idle_grant", grant, 0);
      tick();
      #2;
      check("single_grant", grant, 4'b0010);
      check("single_winc", winc, 1);
      check("single_wdata", wData, 8'hA1);
      wait_writes("single", 3, 20);
      #2;
      check("single_done_busy", busy, 0);
      exp_log("single", 0, 1, 8'hA1);
      exp_log("single", 1, 1, 8'hA2);
      exp_log("single", 2, 1, 8'hA3);
      exp_gap("single", 1, 1);
      exp_gap("single", 2, 1);

      // Fairness: one-word bursts rotate 0,1,2,3,0,... with a bubble between grants.
      do_reset();
      for (int i = 0; i < N; i++) begin
         load(i, 8'h30 + 8'(i), 1'b1);
         load(i, 8'h40 + 8'(i), 1'b1);
      end
      wait_writes("fair", 8, 60);
      for (int k = 0; k < 8; k++) begin
         exp_log("fair", k, k % 4, ((k < 4) ? 8'h30 : 8'h40) + (k % 4));
         if (k > 0) exp_gap("fair", k, 2);
      end

      // Burst cap: req2 streams without last, req3 waits and takes the next grant.
      do_reset();
      for (int j = 0; j < 6; j++) load(2, 8'h20 + 8'(j), 1'b0);
      load(3, 8'h33, 1'b1);
      wait_writes("cap", 7, 60);
      exp_log("cap", 0, 2, 8'h20);
      exp_log("cap", 3, 2, 8'h23);
      exp_log("cap", 4, 3, 8'h33);
      exp_log("cap", 5, 2, 8'h24);
      exp_log("cap", 6, 2, 8'h25);
      exp_gap("cap", 3, 1);
      exp_gap("cap", 4, 2);

      // Full stall after two words; the word count survives the stall.
      do_reset();
      for (int j = 0; j < 5; j++) load(0, 8'h50 + 8'(j), 1'b0);
      wait_writes("stall_pre", 2, 20);
      wFull = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #2;
         check($sformatf("stall_grant%0d", k), grant, 4'b0001);
         check($sformatf("stall_winc%0d", k), winc, 0);
         tick();
      end
      wFull = 1'b0;
      wait_writes("stall", 5, 30);
      for (int k = 0; k < 5; k++) exp_log("stall", k, 0, 8'h50 + k);
      exp_gap("stall", 1, 1);
      exp_gap("stall", 2, 6);
      exp_gap("stall", 3, 1);
      exp_gap("stall", 4, 2);

      // Owner drops req after one word; pointer moves past it to req2.
      do_reset();
      load(1, 8'h61, 1'b0);
      wait_writes("drop_pre", 1, 20);
      load(0, 8'h70, 1'b1);
      load(2, 8'h72, 1'b1);
      #2;
      check("drop_busy_end", busy, 1);
      check("drop_winc_end", winc, 0);
      tick();
      #2;
      check("drop_idle_busy", busy, 0);
      check("drop_idle_grant", grant, 0);
      wait_writes("drop", 3, 30);
      exp_log("drop", 0, 1, 8'h61);
      exp_log("drop", 1, 2, 8'h72);
      exp_log("drop", 2, 0, 8'h70);
      repeat (2) tick();

      // Reset mid-burst: grant drops and the pointer returns to 0.
      clear_logs();
      for (int j = 0; j < 4; j++) load(2, 8'h90 + 8'(j), 1'b0);
      wait_writes("mrst_pre", 1, 20);
      wrst = 1'b0;
      tick();
      wrst = 1'b1;
      load(0, 8'hA0, 1'b1);
      #2;
      check("mrst_grant", grant, 0);
      check("mrst_winc", winc, 0);
      check("mrst_busy", busy, 0);
      tick();
      #2;
      check("mrst_regrant", grant, 4'b0001);
      wait_writes("mrst", 5, 30);
      exp_log("mrst", 0, 2, 8'h90);
      exp_log("mrst", 1, 2, 8'h91);
      exp_log("mrst", 2, 0, 8'hA0);
      exp_log("mrst", 3, 2, 8'h92);
      exp_log("mrst", 4, 2, 8'h93);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
